// File: rtl/nmr_voter_if.sv
// Bundle of the voter's sample input and voted-result output signals.
// The producer side uses the master modport and the voter uses the slave modport.
interface nmr_voter_if #(
  parameter int N_CH = 3,
  parameter int W    = 8
);
  logic              valid_in;
  logic [N_CH*W-1:0] data_in;
  logic              clear_fault;
  logic              valid_out;
  logic [W-1:0]      data_out;
  logic              agree;
  logic              no_majority;
  logic [N_CH-1:0]   mismatch;
  logic [N_CH-1:0]   fault;

  modport master (
    output valid_in, data_in, clear_fault,
    input  valid_out, data_out, agree, no_majority, mismatch, fault
  );

  modport slave (
    input  valid_in, data_in, clear_fault,
    output valid_out, data_out, agree, no_majority, mismatch, fault
  );
endinterface

// File: rtl/nmr_voter.sv
// Registered N-modular-redundancy voter with per-channel disagreement counters.
// A channel that disagrees for FAULT_THR consecutive voted samples is latched faulted and masked out.
module nmr_voter #(
  parameter int N_CH      = 3,
  parameter int W         = 8,
  parameter int FAULT_THR = 4
) (
  input logic       clk,
  input logic       rst,
  nmr_voter_if.slave bus
);
  localparam int                CNT_W = $clog2(FAULT_THR + 1);
  localparam logic [CNT_W-1:0]  THR   = CNT_W'(FAULT_THR);

  logic                       validOut_q;
  logic [W-1:0]               dataOut_q;
  logic                       agree_q;
  logic                       noMajority_q;
  logic [N_CH-1:0]            mismatch_q;
  logic [N_CH-1:0]            fault_q,  fault_d;
  logic [N_CH-1:0][CNT_W-1:0] cnt_q,    cnt_d;

  logic [N_CH-1:0] active;
  logic [W-1:0]    vote;
  logic [W-1:0]    tie;
  logic [N_CH-1:0] mismatchNow;
  logic            agreeNow;
  logic            noMajorityNow;
  int              nActive;
  int              ones;

  // Bitwise majority over the channels not yet faulted; a tie keeps the previous output bit.
  always_comb begin
    active  = ~fault_q;
    nActive = 0;
    for (int c = 0; c < N_CH; c++) begin
      if (active[c]) nActive = nActive + 1;
    end
    vote = '0;
    tie  = '0;
    ones = 0;
    for (int b = 0; b < W; b++) begin
      ones = 0;
      for (int c = 0; c < N_CH; c++) begin
        if (active[c] && bus.data_in[c*W + b]) ones = ones + 1;
      end
      if (2 * ones > nActive) begin
        vote[b] = 1'b1;
      end else if (2 * ones < nActive) begin
        vote[b] = 1'b0;
      end else begin
        vote[b] = dataOut_q[b];
        tie[b]  = 1'b1;
      end
    end
    mismatchNow = '0;
    for (int c = 0; c < N_CH; c++) begin
      mismatchNow[c] = active[c] && (bus.data_in[c*W +: W] != vote);
    end
    noMajorityNow = (|tie) || (nActive == 0);
    agreeNow      = (nActive > 0) && (mismatchNow == '0);
  end

  // Counters only move on an untied sample; clear_fault overrides any update in the same cycle.
  always_comb begin
    cnt_d   = cnt_q;
    fault_d = fault_q;
    if (bus.clear_fault) begin
      cnt_d   = '0;
      fault_d = '0;
    end else if (bus.valid_in && !noMajorityNow) begin
      for (int c = 0; c < N_CH; c++) begin
        if (active[c]) begin
          if (mismatchNow[c]) begin
            if (cnt_q[c] != THR) cnt_d[c] = cnt_q[c] + 1'b1;
            if (cnt_d[c] == THR) fault_d[c] = 1'b1;
          end else begin
            cnt_d[c] = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      validOut_q   <= 1'b0;
      dataOut_q    <= '0;
      agree_q      <= 1'b0;
      noMajority_q <= 1'b0;
      mismatch_q   <= '0;
      fault_q      <= '0;
      cnt_q        <= '0;
    end else begin
      validOut_q <= bus.valid_in;
      if (bus.valid_in) begin
        dataOut_q    <= vote;
        agree_q      <= agreeNow;
        noMajority_q <= noMajorityNow;
        mismatch_q   <= mismatchNow;
      end
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.valid_out   = validOut_q;
  assign bus.data_out    = dataOut_q;
  assign bus.agree       = agree_q;
  assign bus.no_majority = noMajority_q;
  assign bus.mismatch    = mismatch_q;
  assign bus.fault       = fault_q;
endmodule

// File: tb/tb_nmr_voter.sv
// Self-checking bench for nmr_voter: directed scenarios followed by randomized samples,
// all compared against a behavioural model of the voting and fault-isolation rules.
module tb_nmr_voter;
  localparam int N_CH = 3;
  localparam int W    = 8;
  localparam int THR  = 4;

  logic clk;
  logic rst;

  nmr_voter_if #(.N_CH(N_CH), .W(W)) bus ();

  nmr_voter #(.N_CH(N_CH), .W(W), .FAULT_THR(THR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  // Model state: expected registered outputs plus per-channel consecutive-disagreement counts.
  logic         eValid;
  logic [W-1:0] eData;
  logic         eAgree;
  logic         eNoMaj;
  logic [2:0]   eMism;
  logic [2:0]   eFault;
  int           mCnt [N_CH];

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic modelStep(input logic v, input logic [N_CH*W-1:0] d, input logic clr, input logic r);
    int           n;
    int           k;
    logic [W-1:0] voted;
    logic [2:0]   mm;
    logic [2:0]   newFault;
    bit           anyTie;
    logic [W-1:0] word;
    if (r) begin
      eValid = 0; eData = '0; eAgree = 0; eNoMaj = 0; eMism = '0; eFault = '0;
      for (int c = 0; c < N_CH; c++) mCnt[c] = 0;
      return;
    end
    eValid   = v;
    newFault = eFault;
    if (v) begin
      n = 0;
      for (int c = 0; c < N_CH; c++) if (!eFault[c]) n++;
      anyTie = (n == 0);
      voted  = '0;
      for (int b = 0; b < W; b++) begin
        k = 0;
        for (int c = 0; c < N_CH; c++) if (!eFault[c] && d[c*W + b]) k++;
        if (2 * k > n) voted[b] = 1'b1;
        else if (2 * k < n) voted[b] = 1'b0;
        else begin
          voted[b] = eData[b];
          anyTie   = 1;
        end
      end
      for (int c = 0; c < N_CH; c++) begin
        word  = d[c*W +: W];
        mm[c] = !eFault[c] && (word != voted);
      end
      if (!clr && !anyTie) begin
        for (int c = 0; c < N_CH; c++) begin
          if (!eFault[c]) begin
            if (mm[c]) begin
              if (mCnt[c] < THR) mCnt[c]++;
              if (mCnt[c] == THR) newFault[c] = 1'b1;
            end else begin
              mCnt[c] = 0;
            end
          end
        end
      end
      eData  = voted;
      eNoMaj = anyTie;
      eAgree = (n > 0) && (mm == 3'b000);
      eMism  = mm;
    end
    eFault = newFault;
    if (clr) begin
      eFault = '0;
      for (int c = 0; c < N_CH; c++) mCnt[c] = 0;
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".valid_out"},   32'(bus.valid_out),   32'(eValid));
    checkVal({tag, ".data_out"},    32'(bus.data_out),    32'(eData));
    checkVal({tag, ".agree"},       32'(bus.agree),       32'(eAgree));
    checkVal({tag, ".no_majority"}, 32'(bus.no_majority), 32'(eNoMaj));
    checkVal({tag, ".mismatch"},    32'(bus.mismatch),    32'(eMism));
    checkVal({tag, ".fault"},       32'(bus.fault),       32'(eFault));
  endtask

  task automatic applyStimulus(input string tag, input logic v, input logic [N_CH*W-1:0] d,
                               input logic clr, input logic r);
    bus.valid_in    = v;
    bus.data_in     = d;
    bus.clear_fault = clr;
    rst             = r;
    modelStep(v, d, clr, r);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [W-1:0] base;
    logic [W-1:0] ch [N_CH];
    int           sick;
    rst             = 1'b1;
    bus.valid_in    = 1'b0;
    bus.data_in     = '0;
    bus.clear_fault = 1'b0;
    modelStep(0, '0, 0, 1);

    applyStimulus("reset0", 0, 24'h123456, 0, 1);
    applyStimulus("reset1", 1, 24'h123456, 0, 1);
    applyStimulus("idle", 0, 24'h000000, 0, 0);

    applyStimulus("unanimous", 1, 24'hA5A5A5, 0, 0);
    checkVal("unanimous.const_data", 32'(bus.data_out), 32'h A5);
    checkVal("unanimous.const_agree", 32'(bus.agree), 32'h1);

    applyStimulus("bitwise", 1, 24'h0F00FF, 0, 0);
    checkVal("bitwise.const_data", 32'(bus.data_out), 32'h0F);
    checkVal("bitwise.const_mism", 32'(bus.mismatch), 32'h3);
    applyStimulus("holdIdle", 0, 24'hFFFFFF, 0, 0);
    applyStimulus("clr0", 1, 24'h777777, 1, 0);

    // ch1 disagrees three times, agrees once, then disagrees three more times.
    for (int i = 0; i < 3; i++) applyStimulus("ch1miss", 1, 24'h555A55, 0, 0);
    applyStimulus("ch1match", 1, 24'h555555, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus("ch1miss2", 1, 24'h555A55, 0, 0);
    checkVal("counterReset.const_fault", 32'(bus.fault), 32'h0);
    applyStimulus("clr1", 1, 24'h000000, 1, 0);

    for (int i = 0; i < 4; i++) applyStimulus("ch2fault", 1, 24'h003C3C, 0, 0);
    checkVal("ch2fault.const_fault", 32'(bus.fault), 32'h4);
    applyStimulus("tiePair", 1, 24'h002211, 0, 0);
    checkVal("tiePair.const_data", 32'(bus.data_out), 32'h30);
    checkVal("tiePair.const_nomaj", 32'(bus.no_majority), 32'h1);
    applyStimulus("clr2", 1, 24'h000000, 1, 0);

    for (int i = 0; i < 3; i++) applyStimulus("ch2pre", 1, 24'hC38181, 0, 0);
    applyStimulus("ch2clr", 1, 24'hC39191, 1, 0);
    checkVal("ch2clr.const_fault", 32'(bus.fault), 32'h0);
    checkVal("ch2clr.const_data", 32'(bus.data_out), 32'h91);
    for (int i = 0; i < 3; i++) applyStimulus("ch2post", 1, 24'hC38181, 0, 0);
    checkVal("ch2post.const_fault", 32'(bus.fault), 32'h0);
    applyStimulus("clr3", 0, 24'h000000, 1, 0);

    // Every channel disagrees with the 07 vote, so all three fault together.
    for (int i = 0; i < 4; i++) applyStimulus("allFault", 1, 24'h060503, 0, 0);
    checkVal("allFault.const_fault", 32'(bus.fault), 32'h7);
    applyStimulus("noActive", 1, 24'hFFFFFF, 0, 0);
    checkVal("noActive.const_data", 32'(bus.data_out), 32'h07);
    checkVal("noActive.const_nomaj", 32'(bus.no_majority), 32'h1);
    applyStimulus("midReset", 1, 24'h111111, 0, 1);
    checkVal("midReset.const_valid", 32'(bus.valid_out), 32'h0);

    sick = 0;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) sick = int'($urandom_range(0, N_CH - 1));
      base = W'($urandom);
      for (int c = 0; c < N_CH; c++) begin
        ch[c] = base;
        if ($urandom_range(0, 7) == 0) ch[c] = W'($urandom);
      end
      if ($urandom_range(0, 2) != 0) ch[sick] = base ^ W'($urandom_range(1, 255));
      applyStimulus("random", ($urandom_range(0, 3) != 0), {ch[2], ch[1], ch[0]},
                    ($urandom_range(0, 29) == 0), ($urandom_range(0, 149) == 0));
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
